pdu_ctrl: RTL and testbench

- Control sequencer for the PDU; sits directly after the debounce/pulse stage.
- Consumes the one-cycle key pulses (step, cont, chk, ent, del, 16 hex keys) and drives the CPU run enable.
- Owns the hex-entry buffer and runs the input handshake when the CPU requests a value.
- Also maintains the memory/register check address shown on the display.

---
 rtl/pdu_pkg.sv | 20 ++
 rtl/pdu_ctrl_hex_entry.sv | 53 +++++
 rtl/pdu_ctrl.sv | 125 ++++++++++++
 tb/tb_pdu_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pdu_pkg.sv
// Shared definitions for the PDU control sequencer: FSM encodings and default widths.
// No logic; imported by pdu_ctrl and hex_entry.
package pdu_pkg;

    typedef enum logic [1:0] {
        HALT    = 2'd0,
        CONT    = 2'd1,
        STEP    = 2'd2,
        WAIT_IN = 2'd3
    } state_t;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 8;
    localparam int DIGITS = DW_DEF / 4;

    function automatic int cnt_width(input int dw);
        return $clog2(dw / 4) + 1;
    endfunction

endpackage

// File: rtl/pdu_ctrl_hex_entry.sv
// Hex-entry shift buffer: one-hot key decode, digit shift-in, delete, clear.
// One-cycle update latency; no backpressure, clr overrides any edit in the same cycle.
module hex_entry
    import pdu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = cnt_width(DW)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [15:0]   hd_ps,
    input  logic          del_ps,
    input  logic          clr,
    output logic [DW-1:0] data_buf,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DW / 4);

    logic       one_hot;
    logic [3:0] code;

    always_comb begin
        one_hot = (hd_ps != 16'd0) && ((hd_ps & (hd_ps - 16'd1)) == 16'd0);
        code    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hd_ps[i]) code = 4'(i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_buf <= '0;
            cnt      <= '0;
        end else if (clr) begin
            data_buf <= '0;
            cnt      <= '0;
        end else if (en) begin
            // Delete takes priority; a digit pressed alongside it is dropped.
            if (del_ps) begin
                if (cnt != '0) begin
                    data_buf <= data_buf >> 4;
                    cnt      <= cnt - CW'(1);
                end
            end else if (one_hot) begin
                data_buf <= {data_buf[DW-5:0], code};
                if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pdu_ctrl.sv
// PDU run/step sequencer with check-address counter and CPU input handshake.
// All outputs registered (one-cycle latency); in_vld holds until in_ack is seen.
module pdu_ctrl
    import pdu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     step_ps,
    input  logic                     cont_ps,
    input  logic                     chk_ps,
    input  logic                     ent_ps,
    input  logic                     del_ps,
    input  logic [15:0]              hd_ps,
    input  logic                     brk,
    input  logic                     in_req,
    input  logic                     in_ack,
    output logic                     run,
    output logic [DW-1:0]            in_data,
    output logic                     in_vld,
    output logic [DW-1:0]            disp_buf,
    output logic [$clog2(DW/4):0]    digit_cnt,
    output logic [AW-1:0]            chk_addr,
    output logic [1:0]               state_o
);

    localparam int CW = $clog2(DW / 4) + 1;

    state_t state, state_nxt;
    logic   ret_cont, ret_nxt;
    logic   edit_en, ent_go, hand_load, hand_done, chk_inc, chk_load;

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_cont;
        edit_en   = 1'b0;
        ent_go    = 1'b0;
        hand_load = 1'b0;
        hand_done = 1'b0;
        chk_inc   = 1'b0;
        chk_load  = 1'b0;
        case (state)
            HALT: begin
                edit_en = 1'b1;
                if (cont_ps)      state_nxt = CONT;
                else if (step_ps) state_nxt = STEP;
                // A committed entry outranks a same-cycle chk advance on chk_addr.
                if (ent_ps && digit_cnt != '0) begin
                    chk_load = 1'b1;
                    ent_go   = 1'b1;
                end else if (chk_ps) begin
                    chk_inc = 1'b1;
                end
            end
            STEP: begin
                if (in_req) begin
                    state_nxt = WAIT_IN;
                    ret_nxt   = 1'b0;
                end else begin
                    state_nxt = HALT;
                end
            end
            CONT: begin
                if (cont_ps || brk) begin
                    state_nxt = HALT;
                end else if (in_req) begin
                    state_nxt = WAIT_IN;
                    ret_nxt   = 1'b1;
                end
            end
            WAIT_IN: begin
                edit_en = 1'b1;
                if (in_vld) begin
                    if (in_ack) begin
                        hand_done = 1'b1;
                        state_nxt = ret_cont ? CONT : HALT;
                    end
                end else if (ent_ps && digit_cnt != '0) begin
                    hand_load = 1'b1;
                    ent_go    = 1'b1;
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= HALT;
            ret_cont <= 1'b0;
            run      <= 1'b0;
            in_vld   <= 1'b0;
            in_data  <= '0;
            chk_addr <= '0;
        end else begin
            state    <= state_nxt;
            ret_cont <= ret_nxt;
            run      <= (state_nxt == CONT) || (state_nxt == STEP);
            if (hand_load) begin
                in_data <= disp_buf;
                in_vld  <= 1'b1;
            end else if (hand_done) begin
                in_vld  <= 1'b0;
            end
            if (chk_load)     chk_addr <= disp_buf[AW-1:0];
            else if (chk_inc) chk_addr <= chk_addr + AW'(1);
        end
    end

    hex_entry #(.DW(DW), .CW(CW)) u_hex_entry (
        .clk      (clk),
        .rstn     (rstn),
        .en       (edit_en),
        .hd_ps    (hd_ps),
        .del_ps   (del_ps),
        .clr      (ent_go),
        .data_buf (disp_buf),
        .cnt      (digit_cnt)
    );

    assign state_o = state;

endmodule

// File: tb/tb_pdu_ctrl.sv
// Directed self-checking bench for pdu_ctrl (DW=32, AW=8).
module tb_pdu_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        step_ps, cont_ps, chk_ps, ent_ps, del_ps;
    logic [15:0] hd_ps;
    logic        brk, in_req, in_ack;
    logic        run;
    logic [31:0] in_data;
    logic        in_vld;
    logic [31:0] disp_buf;
    logic [3:0]  digit_cnt;
    logic [7:0]  chk_addr;
    logic [1:0]  state_o;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int run_cnt = 0;
    int vld_cnt;

    always #5 clk = ~clk;

    pdu_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .step_ps   (step_ps),
        .cont_ps   (cont_ps),
        .chk_ps    (chk_ps),
        .ent_ps    (ent_ps),
        .del_ps    (del_ps),
        .hd_ps     (hd_ps),
        .brk       (brk),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .run       (run),
        .in_data   (in_data),
        .in_vld    (in_vld),
        .disp_buf  (disp_buf),
        .digit_cnt (digit_cnt),
        .chk_addr  (chk_addr),
        .state_o   (state_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (run === 1'b1) run_cnt++;
    endtask

    task automatic key(input int k);
        hd_ps = 16'd1 << k;
        tick();
        hd_ps = 16'd0;
    endtask

    initial begin
        rstn = 1'b0;
        step_ps = 0; cont_ps = 0; chk_ps = 0; ent_ps = 0; del_ps = 0;
        hd_ps = 16'd0; brk = 0; in_req = 0; in_ack = 0;
        #12;
        check("rst_run", run, 0);
        check("rst_state", state_o, 0);
        check("rst_vld", in_vld, 0);
        check("rst_data", in_data, 0);
        check("rst_buf", disp_buf, 0);
        check("rst_cnt", digit_cnt, 0);
        check("rst_addr", chk_addr, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Single steps: exactly one run cycle each
        run_cnt = 0;
        for (int s = 0; s < 3; s++) begin
            step_ps = 1; tick(); step_ps = 0;
            check("step_run", run, 1);
            check("step_state", state_o, 2);
            tick();
            check("step_back_run", run, 0);
            check("step_back_state", state_o, 0);
        end
        tick(); tick();
        check("step_run_total", run_cnt, 3);

        // Hex entry, delete, commit to chk_addr
        key(1); key(2); key(3);
        check("keys_buf", disp_buf, 32'h123);
        check("keys_cnt", digit_cnt, 3);
        del_ps = 1; tick(); del_ps = 0;
        check("del_buf", disp_buf, 32'h12);
        check("del_cnt", digit_cnt, 2);
        ent_ps = 1; tick(); ent_ps = 0;
        check("ent_addr", chk_addr, 8'h12);
        check("ent_buf", disp_buf, 0);
        check("ent_cnt", digit_cnt, 0);
        chk_ps = 1; tick(); chk_ps = 0;
        check("chk_inc", chk_addr, 8'h13);
        key(15); key(15);
        ent_ps = 1; tick(); ent_ps = 0;
        check("ent_ff", chk_addr, 8'hFF);
        ent_ps = 1; tick(); ent_ps = 0;
        check("ent_empty_ignored", chk_addr, 8'hFF);
        chk_ps = 1; tick(); chk_ps = 0;
        check("chk_wrap", chk_addr, 8'h00);

        // Continuous run halted by breakpoint
        cont_ps = 1; tick(); cont_ps = 0;
        check("cont_state", state_o, 1);
        run_cnt = 0;
        step_ps = 1; chk_ps = 1;
        for (int c = 0; c < 9; c++) begin
            tick();
            step_ps = 0; chk_ps = 0;
        end
        check("cont_run_cycles", run_cnt, 9);
        check("cont_chk_ignored", chk_addr, 8'h00);
        brk = 1; tick(); brk = 0;
        check("brk_run", run, 0);
        check("brk_state", state_o, 0);

        // Input handshake from CONT, returning to CONT
        cont_ps = 1; tick(); cont_ps = 0;
        in_req = 1; tick();
        check("req_state", state_o, 3);
        check("req_run", run, 0);
        cont_ps = 1; key(10); cont_ps = 0;
        check("wait_cont_ignored", state_o, 3);
        key(11);
        ent_ps = 1; tick(); ent_ps = 0;
        check("hs_vld", in_vld, 1);
        check("hs_data", in_data, 32'hAB);
        check("hs_buf_clr", disp_buf, 0);
        key(12);
        ent_ps = 1; tick(); ent_ps = 0;
        vld_cnt = 0;
        for (int w = 0; w < 4; w++) begin
            if (in_vld === 1'b1) vld_cnt++;
            tick();
        end
        check("hs_vld_hold", vld_cnt, 4);
        check("hs_ent_ignored_data", in_data, 32'hAB);
        check("hs_ent_ignored_buf", disp_buf, 32'hC);
        in_ack = 1; in_req = 0; tick(); in_ack = 0;
        check("ack_vld", in_vld, 0);
        check("ack_state", state_o, 1);
        check("ack_run", run, 1);
        cont_ps = 1; tick(); cont_ps = 0;
        check("halt_again", state_o, 0);
        del_ps = 1; tick(); del_ps = 0;
        check("clear_c", digit_cnt, 0);

        // Input request during a single step returns to HALT
        step_ps = 1; in_req = 1; tick(); step_ps = 0;
        check("step_req_state", state_o, 2);
        tick();
        check("step_wait_state", state_o, 3);
        key(5);
        ent_ps = 1; tick(); ent_ps = 0;
        check("step_hs_data", in_data, 32'h5);
        in_req = 0; in_ack = 1; tick(); in_ack = 0;
        check("step_ack_state", state_o, 0);
        check("step_ack_run", run, 0);

        // Buffer full, invalid keys, del vs digit, ent vs digit
        for (int k = 1; k <= 9; k++) key(k);
        check("full_buf", disp_buf, 32'h23456789);
        check("full_cnt", digit_cnt, 8);
        hd_ps = 16'h0003; tick(); hd_ps = 0;
        check("multi_key_buf", disp_buf, 32'h23456789);
        check("multi_key_cnt", digit_cnt, 8);
        del_ps = 1; hd_ps = 16'h0020; tick(); del_ps = 0; hd_ps = 0;
        check("del_wins_buf", disp_buf, 32'h02345678);
        check("del_wins_cnt", digit_cnt, 7);
        ent_ps = 1; hd_ps = 16'h0002; tick(); ent_ps = 0; hd_ps = 0;
        check("ent_wins_addr", chk_addr, 8'h78);
        check("ent_wins_buf", disp_buf, 0);
        del_ps = 1; tick(); del_ps = 0;
        check("del_empty_cnt", digit_cnt, 0);

        // Asynchronous reset in the middle of a pending handshake
        cont_ps = 1; tick(); cont_ps = 0;
        in_req = 1; tick();
        key(7);
        ent_ps = 1; tick(); ent_ps = 0;
        check("pre_rst_vld", in_vld, 1);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_vld", in_vld, 0);
        check("arst_data", in_data, 0);
        check("arst_addr", chk_addr, 0);
        check("arst_state", state_o, 0);
        check("arst_run", run, 0);
        in_req = 0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("post_rst_state", state_o, 0);
        check("post_rst_run", run, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
